// File: rtl/writeback_commit.sv
// Purpose: in-order DEPTH-entry commit queue between memory stage and retirement; drives RF/CSR writes, trace, traps and forwarding.
// Latency: 1 cycle minimum from m_valid&m_ready to c_valid; write enables are combinational from the commit handshake.
// Backpressure: m_ready drops when full (no pop-bypass) or while an exception retires; optional counter under WB_INSTRET_EN.
module writeback_commit #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 4,
    parameter int NFWD   = 2,
    parameter int CSR_AW = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [XLEN-1:0]        m_pc,
    input  logic [31:0]            m_instr,
    input  logic                   m_regwrite,
    input  logic [4:0]             m_dst,
    input  logic [XLEN-1:0]        m_regdata,
    input  logic                   m_csrwrite,
    input  logic [CSR_AW-1:0]      m_csr_dst,
    input  logic [XLEN-1:0]        m_csrdata,
    input  logic                   m_skip,
    input  logic                   m_ex,
    input  logic [3:0]             m_ex_cause,
    input  logic                   c_ready,
    output logic                   c_valid,
    output logic [XLEN-1:0]        c_pc,
    output logic [31:0]            c_instr,
    output logic                   c_skip,
    output logic                   rf_we,
    output logic [4:0]             rf_wa,
    output logic [XLEN-1:0]        rf_wd,
    output logic                   csr_we,
    output logic [CSR_AW-1:0]      csr_wa,
    output logic [XLEN-1:0]        csr_wd,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        ex_pc,
    output logic [3:0]             ex_cause,
    input  logic [NFWD*5-1:0]      fwd_rs,
    output logic [NFWD-1:0]        fwd_hit,
    output logic [NFWD*XLEN-1:0]   fwd_data
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]            instret
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [31:0]       instr;
        logic              regwrite;
        logic [4:0]        dst;
        logic [XLEN-1:0]   regdata;
        logic              csrwrite;
        logic [CSR_AW-1:0] csr_dst;
        logic [XLEN-1:0]   csrdata;
        logic              skip;
        logic              ex;
        logic [3:0]        ex_cause;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    entry_t          head_e;
    entry_t          in_e;
    logic            vld;
    logic            enq;
    logic            fire;
    logic            ex_fire;

    assign head_e = mem_q[head_q];

    // Head is only presented outside reset so no write can leak during the reset cycle.
    assign vld     = (count_q != '0) && !reset;
    assign fire    = vld && c_ready;
    assign ex_fire = fire && head_e.ex;
    assign m_ready = (count_q != CW'(DEPTH)) && !ex_fire;
    assign enq     = m_valid && m_ready;

    assign in_e = '{pc: m_pc, instr: m_instr, regwrite: m_regwrite, dst: m_dst,
                    regdata: m_regdata, csrwrite: m_csrwrite, csr_dst: m_csr_dst,
                    csrdata: m_csrdata, skip: m_skip, ex: m_ex, ex_cause: m_ex_cause};

    // Head-entry presentation; data outputs read as zero while nothing is presented.
    assign c_valid  = vld;
    assign c_pc     = vld ? head_e.pc : '0;
    assign c_instr  = vld ? head_e.instr : '0;
    assign c_skip   = vld && head_e.skip;
    assign rf_we    = fire && head_e.regwrite && (head_e.dst != 5'd0) && !head_e.ex;
    assign rf_wa    = vld ? head_e.dst : '0;
    assign rf_wd    = vld ? head_e.regdata : '0;
    assign csr_we   = fire && head_e.csrwrite && !head_e.ex;
    assign csr_wa   = vld ? head_e.csr_dst : '0;
    assign csr_wd   = vld ? head_e.csrdata : '0;
    assign ex_valid = ex_fire;
    assign ex_pc    = ex_fire ? head_e.pc : '0;
    assign ex_cause = ex_fire ? head_e.ex_cause : '0;

    // Pointer/count next state: a retiring exception flushes everything younger.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (ex_fire) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + 1'b1;
            end
            if (fire) begin
                head_d = head_q + 1'b1;
            end
            if (enq && !fire) begin
                count_d = count_q + 1'b1;
            end else if (!enq && fire) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: written once at enqueue, never modified afterwards.
    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            mem_q[tail_q] <= in_e;
        end
    end

    // Forwarding: walk oldest to youngest so the youngest valid match wins.
    always_comb begin
        logic [PW-1:0] slot;
        logic [4:0]    rs;
        entry_t        e;
        fwd_hit  = '0;
        fwd_data = '0;
        slot     = '0;
        rs       = '0;
        e        = '0;
        for (int i = 0; i < NFWD; i++) begin
            rs = fwd_rs[i*5 +: 5];
            for (int k = 0; k < DEPTH; k++) begin
                slot = head_q + PW'(k);
                e    = mem_q[slot];
                if (!reset && (CW'(k) < count_q) && e.regwrite && !e.ex &&
                    (e.dst == rs) && (rs != 5'd0)) begin
                    fwd_hit[i]                 = 1'b1;
                    fwd_data[i*XLEN +: XLEN]   = e.regdata;
                end
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Retired-instruction count: every non-exception commit, wrapping naturally.
    always_comb begin
        instret_d = instret_q;
        if (fire && !head_e.ex) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_commit.sv
// Bench for writeback_commit: directed scenarios followed by randomized traffic,
// every cycle checked against a queue-based model of the commit rules.
// Optional retired-instruction counter is checked when WB_INSTRET_EN is defined.
module tb_writeback_commit;

    localparam int XLEN   = 64;
    localparam int DEPTH  = 4;
    localparam int NFWD   = 2;
    localparam int CSR_AW = 12;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        rw;
        logic [4:0]  dst;
        logic [63:0] rd;
        logic        cw;
        logic [11:0] ca;
        logic [63:0] cd;
        logic        skip;
        logic        ex;
        logic [3:0]  cause;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic              m_ready;
    logic [63:0]       m_pc;
    logic [31:0]       m_instr;
    logic              m_regwrite;
    logic [4:0]        m_dst;
    logic [63:0]       m_regdata;
    logic              m_csrwrite;
    logic [11:0]       m_csr_dst;
    logic [63:0]       m_csrdata;
    logic              m_skip;
    logic              m_ex;
    logic [3:0]        m_ex_cause;
    logic              c_ready;
    logic              c_valid;
    logic [63:0]       c_pc;
    logic [31:0]       c_instr;
    logic              c_skip;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [63:0]       rf_wd;
    logic              csr_we;
    logic [11:0]       csr_wa;
    logic [63:0]       csr_wd;
    logic              ex_valid;
    logic [63:0]       ex_pc;
    logic [3:0]        ex_cause;
    logic [NFWD*5-1:0] fwd_rs;
    logic [NFWD-1:0]   fwd_hit;
    logic [NFWD*64-1:0] fwd_data;
`ifdef WB_INSTRET_EN
    logic [63:0]       instret;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    ent_t        mq[$];
    logic [63:0] inst_m = '0;
    logic        acc = 1'b0;

    writeback_commit #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD), .CSR_AW(CSR_AW)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_instr(m_instr),
        .m_regwrite(m_regwrite), .m_dst(m_dst), .m_regdata(m_regdata),
        .m_csrwrite(m_csrwrite), .m_csr_dst(m_csr_dst), .m_csrdata(m_csrdata),
        .m_skip(m_skip), .m_ex(m_ex), .m_ex_cause(m_ex_cause),
        .c_ready(c_ready), .c_valid(c_valid), .c_pc(c_pc), .c_instr(c_instr), .c_skip(c_skip),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_cause(ex_cause),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`ifdef WB_INSTRET_EN
        ,
        .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic rw, input logic [4:0] dst,
                         input logic [63:0] rd, input logic cw, input logic [11:0] ca,
                         input logic [63:0] cd, input logic ex, input logic [3:0] cause);
        m_valid    = v;
        m_pc       = pc;
        m_instr    = pc[31:0] ^ 32'h0000_0013;
        m_regwrite = rw;
        m_dst      = dst;
        m_regdata  = rd;
        m_csrwrite = cw;
        m_csr_dst  = ca;
        m_csrdata  = cd;
        m_skip     = pc[2];
        m_ex       = ex;
        m_ex_cause = cause;
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        ent_t        h;
        ent_t        ne;
        logic        vld, fire, exf, mrdy, rwe, cwe, hit;
        logic [4:0]  rs;
        logic [63:0] d;
        @(negedge clk);
        vld  = (mq.size() != 0) && !reset;
        h    = vld ? mq[0] : '0;
        fire = vld && c_ready;
        exf  = fire && h.ex;
        mrdy = (mq.size() < DEPTH) && !exf;
        rwe  = fire && h.rw && (h.dst != 5'd0) && !h.ex;
        cwe  = fire && h.cw && !h.ex;
        chk("c_valid", 64'(c_valid), 64'(vld));
        if (!reset) chk("m_ready", 64'(m_ready), 64'(mrdy));
        chk("rf_we", 64'(rf_we), 64'(rwe));
        chk("csr_we", 64'(csr_we), 64'(cwe));
        chk("ex_valid", 64'(ex_valid), 64'(exf));
        if (vld) begin
            chk("c_pc", c_pc, h.pc);
            chk("c_instr", 64'(c_instr), 64'(h.instr));
            chk("c_skip", 64'(c_skip), 64'(h.skip));
        end
        if (rwe) begin
            chk("rf_wa", 64'(rf_wa), 64'(h.dst));
            chk("rf_wd", rf_wd, h.rd);
        end
        if (cwe) begin
            chk("csr_wa", 64'(csr_wa), 64'(h.ca));
            chk("csr_wd", csr_wd, h.cd);
        end
        if (exf) begin
            chk("ex_pc", ex_pc, h.pc);
            chk("ex_cause", 64'(ex_cause), 64'(h.cause));
        end
        if (reset) begin
            chk("rst_c_pc", c_pc, 64'd0);
            chk("rst_rf_wd", rf_wd, 64'd0);
            chk("rst_csr_wd", csr_wd, 64'd0);
        end
        for (int p = 0; p < NFWD; p++) begin
            rs  = fwd_rs[p*5 +: 5];
            hit = 1'b0;
            d   = 64'd0;
            if (!reset && rs != 5'd0) begin
                foreach (mq[k]) begin
                    if (mq[k].rw && !mq[k].ex && mq[k].dst == rs) begin
                        hit = 1'b1;
                        d   = mq[k].rd;
                    end
                end
            end
            chk($sformatf("fwd_hit%0d", p), 64'(fwd_hit[p]), 64'(hit));
            chk($sformatf("fwd_data%0d", p), fwd_data[p*64 +: 64], d);
        end
`ifdef WB_INSTRET_EN
        if (!reset) chk("instret", instret, inst_m);
`endif
        acc = m_valid && mrdy && !reset;
        ne  = '{pc: m_pc, instr: m_instr, rw: m_regwrite, dst: m_dst, rd: m_regdata,
                cw: m_csrwrite, ca: m_csr_dst, cd: m_csrdata, skip: m_skip,
                ex: m_ex, cause: m_ex_cause};
        @(posedge clk);
        if (reset) begin
            mq.delete();
            inst_m = '0;
        end else if (exf) begin
            mq.delete();
        end else begin
            if (fire) begin
                void'(mq.pop_front());
                inst_m = inst_m + 64'd1;
            end
            if (acc) mq.push_back(ne);
        end
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        c_ready = 1'b0;
        fwd_rs  = '0;
        idle();
        cycle();
        cycle();
        reset = 1'b0;

        // Single instruction, latency 1, RF write on the commit cycle.
        c_ready = 1'b1;
        drive(1'b1, 64'h8000_0000, 1'b1, 5'd5, 64'h1234, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        idle();
        repeat (3) cycle();

        // Fill to DEPTH with the consumer stalled, fifth held off until space frees.
        c_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0100 + 64'(4*i), 1'b1, 5'(10+i), 64'(100+i), 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
            cycle();
        end
        drive(1'b1, 64'h8000_0110, 1'b1, 5'd14, 64'd104, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        cycle();
        c_ready = 1'b1;
        cycle();
        cycle();
        idle();
        repeat (6) cycle();

        // Forwarding picks the younger of two writers of x3; x0 never hits.
        c_ready = 1'b0;
        drive(1'b1, 64'h8000_0200, 1'b1, 5'd3, 64'hA, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        drive(1'b1, 64'h8000_0204, 1'b1, 5'd3, 64'hB, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        idle();
        fwd_rs = {5'd0, 5'd3};
        cycle();
        fwd_rs = {5'd3, 5'd0};
        cycle();
        c_ready = 1'b1;
        repeat (3) cycle();
        fwd_rs = '0;

        // Exception in the middle: younger entry discarded, enqueue blocked on the trap cycle.
        c_ready = 1'b0;
        drive(1'b1, 64'h8000_0008, 1'b1, 5'd7, 64'hAAAA, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        drive(1'b1, 64'h8000_0010, 1'b1, 5'd8, 64'hBBBB, 1'b0, 12'd0, 64'd0, 1'b1, 4'd2);
        cycle();
        drive(1'b1, 64'h8000_0018, 1'b1, 5'd9, 64'hCCCC, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        cycle();
        fwd_rs = {5'd8, 5'd9};
        drive(1'b1, 64'h8000_0020, 1'b1, 5'd4, 64'hDDDD, 1'b0, 12'd0, 64'd0, 1'b0, 4'd0);
        c_ready = 1'b1;
        repeat (3) cycle();
        idle();
        fwd_rs = '0;
        repeat (3) cycle();

        // dst=0 suppresses the RF write while the CSR write goes through.
        drive(1'b1, 64'h8000_0300, 1'b1, 5'd0, 64'h55, 1'b1, 12'h300, 64'h8, 1'b0, 4'd0);
        cycle();
        idle();
        repeat (2) cycle();

        // Reset with three entries queued: all discarded, no write enables.
        c_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h8000_0400 + 64'(4*i), 1'b1, 5'(1+i), 64'(i+7), 1'b1, 12'h305, 64'd1, 1'b0, 4'd0);
            cycle();
        end
        idle();
        reset   = 1'b1;
        c_ready = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (2) cycle();

        // Randomized traffic; payload held stable until accepted.
        for (int n = 0; n < 600; n++) begin
            if (!(m_valid && !acc)) begin
                drive($urandom_range(0, 9) < 6, {32'h0, $urandom} & ~64'h3,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                      12'($urandom_range(0, 4095)), {$urandom, $urandom},
                      $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
                m_instr = $urandom;
            end
            fwd_rs  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            c_ready = $urandom_range(0, 9) < 7;
            reset   = $urandom_range(0, 99) == 0;
            cycle();
        end
        reset = 1'b0;
        idle();
        c_ready = 1'b1;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
- Parametrised successor to the combinational writeback stage.
- Buffers completed instructions from the memory stage in a DEPTH-entry in-order queue.
- Retires one entry per cycle under a valid/ready handshake: integer register-file write, CSR write, commit trace and precise exception signalling.
- Provides NFWD forwarding lookup ports so decode/execute can bypass from not-yet-retired entries.

Parameters:
- XLEN, 64, data/PC width.
- DEPTH, 4, queue entries; power of two, >=2.
- NFWD, 2, number of forwarding lookup ports.
- CSR_AW, 12, CSR address width.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high reset.
- m_valid in 1: memory stage presents an instruction.
- m_ready out 1: queue can accept.
- m_pc in XLEN: PC.
- m_instr in 32: instruction word.
- m_regwrite in 1: writes integer register file.
- m_dst in 5: destination register.
- m_regdata in XLEN: result.
- m_csrwrite in 1: writes CSR.
- m_csr_dst in CSR_AW: CSR address.
- m_csrdata in XLEN: CSR write data.
- m_skip in 1: difftest skip flag.
- m_ex in 1: instruction raised an exception.
- m_ex_cause in 4: exception cause.
- c_ready in 1: commit consumer accepts.
- c_valid out 1: head entry presented for commit.
- c_pc out XLEN / c_instr out 32 / c_skip out 1: head entry fields.
- rf_we out 1 / rf_wa out 5 / rf_wd out XLEN: register-file write port.
- csr_we out 1 / csr_wa out CSR_AW / csr_wd out XLEN: CSR write port.
- ex_valid out 1 / ex_pc out XLEN / ex_cause out 4: trap request.
- fwd_rs in NFWD*5: lookup register indices.
- fwd_hit out NFWD: a match was found.
- fwd_data out NFWD*XLEN: forwarded data.
- instret out 64: retired-instruction count; present only with WB_INSTRET_EN.

Behaviour:
- Reset:
  - Head, tail and count = 0.
  - c_valid, rf_we, csr_we, ex_valid, fwd_hit = 0.
  - All data outputs = 0; instret = 0.
  - Reset mid-operation discards every entry. No write enable is asserted in the reset cycle or the cycle after.
- Enqueue:
  - enq = m_valid & m_ready.
  - m_ready = (count != DEPTH) & !ex_fire. No pop-bypass when full.
- Output timing:
  - c_* fields are driven from the head entry register.
  - An entry enqueued in cycle t is visible on c_valid no earlier than t+1. Minimum latency is 1; there is no combinational in-to-out path.
- Commit:
  - fire = c_valid & c_ready.
  - rf_we = fire & regwrite & (dst != 0) & !ex.
  - csr_we = fire & csrwrite & !ex.
  - rf_wa/rf_wd and csr_wa/csr_wd are driven from the head entry.
  - Write enables are combinational from fire; the register file and CSR file latch at the next edge.
- Exception:
  - ex_fire = fire & head.ex. In that cycle ex_valid = 1, ex_pc = head.pc, ex_cause = head.ex_cause; no RF/CSR write.
  - At the next edge the whole queue is cleared (younger entries discarded) and count = 0.
  - Any enqueue in the ex_fire cycle is blocked (m_ready = 0).
- Simultaneous enq and fire (non-exception): count is unchanged, head and tail both advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full = count == DEPTH; empty = count == 0.
- Forwarding, per port i:
  - Searches valid entries with regwrite & !ex & dst == fwd_rs[i] & dst != 0.
  - Returns the youngest match (closest to tail), purely combinational.
  - The head entry is included even if it fires this cycle.
  - No match: fwd_hit[i] = 0 and fwd_data[i] = 0.
- Entries are not modified after enqueue.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - 64-bit instret register; +1 on each non-exception fire; wraps at 2^64.
  - Reset to 0; output port present.
- Undefined: no counter and no instret port; all other behaviour is identical.

Test Plan:
- Single instr pc=0x80000000, regwrite, dst=5, data=0x1234, c_ready=1, enq at t0 -> c_valid=1 at t1; rf_we=1, rf_wa=5, rf_wd=0x1234 at t1; instret=1 at t2.
- c_ready=0, DEPTH=4, push 5 instrs back-to-back -> m_ready=0 after the 4th accept. Raise c_ready -> 4 commits in PC order on consecutive cycles, then the 5th.
- Queue holds dst=3 data=0xA then dst=3 data=0xB; fwd_rs[0]=3 -> fwd_hit[0]=1, fwd_data[0]=0xB. fwd_rs[1]=0 -> fwd_hit[1]=0.
- Entries A, B(ex, cause=2, pc=0x80000010), C; commit -> A writes; at B: ex_valid=1, ex_cause=2, ex_pc=0x80000010, rf_we=0. C never commits; count=0 next cycle; instret counts A only.
- regwrite with dst=0 and csrwrite csr_dst=0x300 data=0x8 -> rf_we=0, csr_we=1, csr_wa=0x300, csr_wd=0x8.
- reset asserted with 3 entries queued -> next cycle c_valid=0, m_ready=1, instret=0, no write enables.
